// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width; WIDTH is at least 2, so this is never zero.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_add_cell.sv
// One-bit full adder built from two half-adder cells and an OR gate.
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic bit_sum,
  output logic carry_next
);

  logic s0_s;
  logic c0_s;
  logic c1_s;

  hfa u_hfa0 (.a(a),    .b(b),   .s(s0_s),    .c(c0_s));
  hfa u_hfa1 (.a(s0_s), .b(cin), .s(bit_sum), .c(c1_s));

  assign carry_next = c0_s | c1_s;

endmodule

// File: rtl/hfa.sv
// Half-adder cell shared across the codebase.
module hfa (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands in via start handshake, one bit per clock
// LSB-first, sum and carry-out presented via done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             start_ready_r;
  logic             done_valid_r;
  logic             bit_sum_s;
  logic             carry_next_s;
  logic             accept_s;
  logic             release_s;
  logic             last_s;

  full_add_cell u_fa (
    .a          (a_r[0]),
    .b          (b_r[0]),
    .cin        (carry_r),
    .bit_sum    (bit_sum_s),
    .carry_next (carry_next_s)
  );

  assign accept_s  = start_valid & start_ready_r;
  assign release_s = done_valid_r & done_ready;
  assign last_s    = (cnt_r == CNT_W'(WIDTH - 1));

  // Next-state decode; unused encodings fall back to IDLE.
  always_comb begin
    state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (release_s) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State plus handshake flags; the flags are registered copies of the state decode
  // so start_ready stays low until the first edge after rst is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      start_ready_r <= 1'b0;
      done_valid_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      start_ready_r <= (state_s == IDLE);
      done_valid_r  <= (state_s == DONE);
    end
  end

  // Datapath: load on accept, then shift one bit per RUN cycle into the result MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r      <= a;
            b_r      <= b;
            carry_r  <= cin;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {WIDTH{1'b0}};
          end
        end
        RUN: begin
          result_r <= {bit_sum_s, result_r[WIDTH-1:1]};
          carry_r  <= carry_next_s;
          a_r      <= {1'b0, a_r[WIDTH-1:1]};
          b_r      <= {1'b0, b_r[WIDTH-1:1]};
          cnt_r    <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
        end
        default: begin
          a_r <= a_r;
        end
      endcase
    end
  end

  assign start_ready = start_ready_r;
  assign done_valid  = done_valid_r;
  assign sum_out     = result_r;
  assign cout        = carry_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder with a queue scoreboard of expected {cout,sum}.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_valid = 1'b0;
  logic         done_ready = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         start_ready;
  logic         done_valid;
  logic         cout;
  logic [W-1:0] sum_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [W:0] exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .cin(cin),
    .done_valid(done_valid), .done_ready(done_ready),
    .sum_out(sum_out), .cout(cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Waits for start_ready, presents one operand set for exactly one accepting edge.
  task automatic start_one(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                           output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (start_ready === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      a = va; b = vb; cin = vc; start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({start_ready, done_valid, cout, sum_out} !== 0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b dv=%b cout=%b sum=%h exp all 0",
               start_ready, done_valid, cout, sum_out);
    end
    rst = 1'b0;
    #1;
    total++;
    if (start_ready !== 1'b0) begin
      bad++; $display("FAIL ready_before_edge got=%b exp=0", start_ready);
    end
    @(negedge clk);
    total++;
    if (start_ready !== 1'b1 || done_valid !== 1'b0) begin
      bad++; $display("FAIL ready_after_reset got rdy=%b dv=%b exp rdy=1 dv=0", start_ready, done_valid);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] va, vb;
    logic vc;
    logic [W:0] ve, e;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin va = 8'h0F; vb = 8'h01; vc = 1'b0; ve = 9'h010; end
        1:       begin va = 8'hFF; vb = 8'h01; vc = 1'b0; ve = 9'h100; end
        default: begin va = 8'hFF; vb = 8'hFF; vc = 1'b1; ve = 9'h1FF; end
      endcase
      start_one(va, vb, vc, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL basic_accept got=0 exp=1 (vector %0d)", i); end
      else exp_q.push_back(ve);
      for (int k = 1; k <= W; k++) begin
        @(negedge clk);
        total++;
        if (done_valid !== (k == W)) begin
          bad++; $display("FAIL basic_latency edge %0d got dv=%b exp=%b", k, done_valid, (k == W));
        end
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL basic_queue got=empty exp=1 entry");
      end else begin
        e = exp_q.pop_front();
        if ({cout, sum_out} !== e) begin
          bad++; $display("FAIL basic_result got=%h exp=%h", {cout, sum_out}, e);
        end
      end
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
      total++;
      if (done_valid !== 1'b0 || start_ready !== 1'b1) begin
        bad++; $display("FAIL basic_release got dv=%b rdy=%b exp dv=0 rdy=1", done_valid, start_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] e;
    bit ok, seen;
    start_one(8'h12, 8'h34, 1'b0, ok);
    if (ok) exp_q.push_back(9'h046);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (done_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!seen) begin bad++; $display("FAIL bp_done_timeout got=0 exp=1"); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (done_valid !== 1'b1 || start_ready !== 1'b0 || {cout, sum_out} !== 9'h046) begin
        bad++; $display("FAIL bp_hold cycle %0d got dv=%b rdy=%b res=%h exp dv=1 rdy=0 res=046",
                        k, done_valid, start_ready, {cout, sum_out});
      end
      start_valid = (k == 1);
      a = 8'h55; b = 8'h55; cin = 1'b0;
      @(negedge clk);
    end
    start_valid = 1'b0;
    total++;
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL bp_queue got=empty exp=1 entry");
    end else begin
      e = exp_q.pop_front();
      if ({cout, sum_out} !== e) begin
        bad++; $display("FAIL bp_result got=%h exp=%h", {cout, sum_out}, e);
      end
    end
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (done_valid !== 1'b0 || start_ready !== 1'b1) begin
      bad++; $display("FAIL bp_ignored_start got dv=%b rdy=%b exp dv=0 rdy=1", done_valid, start_ready);
    end
  endtask

  task automatic test_async_reset();
    logic [W:0] e;
    bit ok, seen;
    start_one(8'hAA, 8'h55, 1'b0, ok);
    if (ok) exp_q.push_back(9'h0FF);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (start_ready !== 1'b0 || done_valid !== 1'b0) begin
      bad++; $display("FAIL ar_mid_run got rdy=%b dv=%b exp 0 0", start_ready, done_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({start_ready, done_valid, cout, sum_out} !== 0) begin
      bad++; $display("FAIL ar_immediate got rdy=%b dv=%b cout=%b sum=%h exp all 0",
                      start_ready, done_valid, cout, sum_out);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (start_ready !== 1'b1) begin
      bad++; $display("FAIL ar_ready_after got=%b exp=1", start_ready);
    end
    start_one(8'h03, 8'h04, 1'b0, ok);
    if (ok) exp_q.push_back(9'h007);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (done_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!seen || exp_q.size() == 0) begin
      bad++; $display("FAIL ar_fresh_timeout got seen=%b q=%0d exp seen=1 q=1", seen, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({cout, sum_out} !== e) begin
        bad++; $display("FAIL ar_fresh_result got=%h exp=%h", {cout, sum_out}, e);
      end
    end
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int issued = 0;
    int got_n = 0;
    int last_cyc = -1;
    logic [W:0] e;
    done_ready = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (done_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra_result got=%h exp=none", {cout, sum_out});
        end else begin
          e = exp_q.pop_front();
          if ({cout, sum_out} !== e) begin
            bad++; $display("FAIL b2b_result got=%h exp=%h", {cout, sum_out}, e);
          end
        end
        if (last_cyc >= 0) begin
          total++;
          if (cyc - last_cyc != W + 2) begin
            bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", cyc - last_cyc, W + 2);
          end
        end
        last_cyc = cyc;
        got_n++;
      end
      if (start_ready === 1'b1) begin
        if (issued < 3) begin
          case (issued)
            0:       begin a = 8'h11; b = 8'h22; cin = 1'b0; end
            1:       begin a = 8'hF0; b = 8'h0F; cin = 1'b1; end
            default: begin a = 8'h80; b = 8'h80; cin = 1'b0; end
          endcase
          start_valid = 1'b1;
          exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
          issued++;
        end else begin
          start_valid = 1'b0;
        end
      end
    end
    start_valid = 1'b0;
    done_ready = 1'b0;
    total++;
    if (got_n != 3 || exp_q.size() != 0 || done_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_count got n=%0d q=%0d dv=%b exp n=3 q=0 dv=0", got_n, exp_q.size(), done_valid);
    end
  endtask

  task automatic test_random();
    int issued = 0;
    int got_n = 0;
    logic [W:0] e;
    for (int n = 0; n < 30000 && got_n < 1000; n++) begin
      @(negedge clk);
      done_ready = 1'($urandom_range(0, 1));
      if (done_valid === 1'b1 && done_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_extra_result got=%h exp=none", {cout, sum_out});
        end else begin
          e = exp_q.pop_front();
          if ({cout, sum_out} !== e) begin
            bad++; $display("FAIL rand_result #%0d got=%h exp=%h", got_n, {cout, sum_out}, e);
          end
        end
        got_n++;
      end
      if (start_ready === 1'b1 && issued < 1000) begin
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom_range(0, 1));
        start_valid = 1'b1;
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
        issued++;
      end else begin
        start_valid = 1'($urandom_range(0, 1)) & (issued < 1000);
      end
    end
    start_valid = 1'b0;
    done_ready = 1'b0;
    total++;
    if (got_n != 1000) begin
      bad++; $display("FAIL rand_count got=%0d exp=1000", got_n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
